// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: tracker entries, stage indices, select encoding.
// Register indices are carried at MAX_REG_BITS wide so one struct serves every REG_BITS build.
package pipe_ctrl_pkg;

    localparam int MAX_REG_BITS    = 8;
    localparam int FWD_SEL_REGFILE = 0;

    localparam int STG_EX    = 0;
    localparam int STG_EXMEM = 1;
    localparam int STG_MEMWB = 2;

    typedef logic [MAX_REG_BITS-1:0] reg_idx_t;

    typedef struct packed {
        logic     v;
        reg_idx_t rd;
        logic     rw;
        logic     ld;
    } trk_ent_t;

    typedef struct packed {
        logic     v;
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     use1;
        logic     use2;
        reg_idx_t rd;
        logic     rw;
        logic     ld;
    } ex_ent_t;

    // x0 never creates a dependency.
    function automatic logic src_hit(input reg_idx_t rd, input reg_idx_t rs1, input logic use1,
                                     input reg_idx_t rs2, input logic use2);
        return (rd != '0) && ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority match of one EX source index against the post-EX tracker; youngest eligible producer wins.
// Purely combinational, 0-cycle latency; no flow control of its own.
module pipe_fwd_match
    import pipe_ctrl_pkg::*;
#(
    parameter int FWD_DEPTH      = 2,
    parameter int LOAD_READY_STG = 2,
    parameter int SEL_W          = $clog2(FWD_DEPTH + 1)
) (
    input  reg_idx_t                   src,
    input  logic                       use_src,
    input  trk_ent_t [FWD_DEPTH:1]     trk,
    output logic     [SEL_W-1:0]       sel
);

    // Walk oldest to youngest so the lowest matching stage overwrites the rest.
    always_comb begin
        sel = SEL_W'(FWD_SEL_REGFILE);
        for (int k = FWD_DEPTH; k >= STG_EXMEM; k--) begin
            if (use_src && trk[k].v && trk[k].rw && (trk[k].rd == src) && (src != '0) &&
                (!trk[k].ld || (k >= LOAD_READY_STG)))
                sel = SEL_W'(k);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central forward/load-use/redirect/freeze controller; 0-cycle control from a registered tracker.
// dmem_ready=0 freezes everything and defers redirects; perf counters only with HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_BITS       = 5,
    parameter int FWD_DEPTH      = 2,
    parameter int LOAD_READY_STG = 2,
    parameter int FLUSH_STAGES   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               id_valid,
    input  logic [REG_BITS-1:0]                id_rs1,
    input  logic [REG_BITS-1:0]                id_rs2,
    input  logic                               id_use_rs1,
    input  logic                               id_use_rs2,
    input  logic [REG_BITS-1:0]                id_rd,
    input  logic                               id_regwrite,
    input  logic                               id_memread,
    input  logic                               redirect,
    input  logic                               dmem_ready,
    output logic                               pc_write,
    output logic                               if_id_write,
    output logic                               id_ex_bubble,
    output logic [FLUSH_STAGES-1:0]            flush,
    output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_a,
    output logic [$clog2(FWD_DEPTH+1)-1:0]     fwd_b,
    output logic [31:0]                        stall_cnt,
    output logic [31:0]                        flush_cnt
);

    ex_ent_t                ex_q;
    ex_ent_t                id_ent;
    trk_ent_t [FWD_DEPTH:1] trk_q;
    logic                   redir_pend_q;
    logic                   load_use;
    logic                   redir_go;
    logic                   stall_go;

    always_comb begin
        id_ent      = '0;
        id_ent.v    = 1'b1;
        id_ent.rs1  = reg_idx_t'(id_rs1);
        id_ent.rs2  = reg_idx_t'(id_rs2);
        id_ent.use1 = id_use_rs1;
        id_ent.use2 = id_use_rs2;
        id_ent.rd   = reg_idx_t'(id_rd);
        id_ent.rw   = id_regwrite;
        id_ent.ld   = id_memread;
    end

    // A load stalls ID only while it cannot reach LOAD_READY_STG before the consumer enters EX.
    always_comb begin
        load_use = 1'b0;
        if (id_valid) begin
            if (ex_q.v && ex_q.ld && ex_q.rw && (STG_EX + 1 < LOAD_READY_STG) &&
                src_hit(ex_q.rd, id_ent.rs1, id_use_rs1, id_ent.rs2, id_use_rs2))
                load_use = 1'b1;
            for (int k = STG_EXMEM; k <= FWD_DEPTH; k++) begin
                if (trk_q[k].v && trk_q[k].ld && trk_q[k].rw && (k + 1 < LOAD_READY_STG) &&
                    src_hit(trk_q[k].rd, id_ent.rs1, id_use_rs1, id_ent.rs2, id_use_rs2))
                    load_use = 1'b1;
            end
        end
    end

    assign redir_go = dmem_ready && (redirect || redir_pend_q);
    assign stall_go = dmem_ready && !redir_go && load_use;

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        flush        = '0;
        if (reset) begin
            if (!dmem_ready) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
            end else if (redir_go) begin
                flush = '1;
            end else if (stall_go) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q         <= '0;
            trk_q        <= '0;
            redir_pend_q <= 1'b0;
        end else if (dmem_ready) begin
            redir_pend_q <= 1'b0;
            trk_q[STG_EXMEM] <= {ex_q.v, ex_q.rd, ex_q.rw, ex_q.ld};
            for (int k = STG_EXMEM + 1; k <= FWD_DEPTH; k++)
                trk_q[k] <= trk_q[k-1];
            if (redir_go || stall_go || !id_valid)
                ex_q <= '0;
            else
                ex_q <= id_ent;
        end else if (redirect) begin
            redir_pend_q <= 1'b1;
        end
    end

    pipe_fwd_match #(
        .FWD_DEPTH      (FWD_DEPTH),
        .LOAD_READY_STG (LOAD_READY_STG)
    ) u_fwd_a (
        .src     (ex_q.rs1),
        .use_src (ex_q.v && ex_q.use1),
        .trk     (trk_q),
        .sel     (fwd_a)
    );

    pipe_fwd_match #(
        .FWD_DEPTH      (FWD_DEPTH),
        .LOAD_READY_STG (LOAD_READY_STG)
    ) u_fwd_b (
        .src     (ex_q.rs2),
        .use_src (ex_q.v && ex_q.use2),
        .trk     (trk_q),
        .sel     (fwd_b)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((!dmem_ready || stall_go) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (redir_go && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
